// File: rtl/shift8_byte_fifo_pkg.sv
// ============================================================================
// Module   : shift8_pkg
// Brief    : Shared constants and sizing helpers for the shift8 byte FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package shift8_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 4;

  // Smallest r with 2**r >= value; used for pointer and occupancy widths.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Occupancy must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return clog2(depth + 1);
  endfunction

  localparam int CNT_W_DEF = cnt_width(DEPTH_DEF);

endpackage

`default_nettype wire

// File: rtl/shift8_byte_fifo_if.sv
// ============================================================================
// Module   : shift8_byte_fifo_if
// Brief    : Upstream byte strobe and downstream valid/ready bundle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface shift8_byte_fifo_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  // FIFO side
  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data,
    input  out_ready
  );

  // Producer/consumer side
  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data,
    output out_ready
  );

endinterface

`default_nettype wire

// File: rtl/shift8_byte_fifo_wrap_ptr.sv
// ============================================================================
// Module   : shift8_wrap_ptr
// Brief    : Mod-DEPTH pointer with enable; DEPTH is a power of two so the
//            pointer wraps by natural overflow.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift8_wrap_ptr
  import shift8_pkg::*;
#(
  parameter  int DEPTH = DEPTH_DEF,
  localparam int PTR_W = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  output logic [PTR_W-1:0] ptr
);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (en) ptr_d = ptr_q + PTR_W'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

`default_nettype wire

// File: rtl/shift8_byte_fifo.sv
// ============================================================================
// Module   : shift8_byte_fifo
// Brief    : First-word-fall-through byte FIFO behind the shift stage; drops
//            and flags bytes offered while full.
//            Optional: SHIFT8_FIFO_DROPCNT_EN adds a saturating drop counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift8_byte_fifo
  import shift8_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEF,
  parameter  int DEPTH = DEPTH_DEF,
  localparam int PTR_W = clog2(DEPTH),
  localparam int CNT_W = cnt_width(DEPTH)
) (
  input  logic                 clk,
  input  logic                 resetn,
  shift8_byte_fifo_if.slave    bus,
  output logic [CNT_W-1:0]     count,
`ifdef SHIFT8_FIFO_DROPCNT_EN
  output logic [7:0]           drop_cnt,
`endif
  output logic                 overflow
);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             drop;

  // Full is taken from the pre-edge count, so a same-cycle pop never frees a slot.
  always_comb begin
    full  = (count_q == CNT_W'(DEPTH));
    empty = (count_q == '0);
    push  = bus.in_valid && !full;
    pop   = !empty && bus.out_ready;
    drop  = bus.in_valid && full;
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr] = bus.in_data;
  end

  shift8_wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk    (clk),
    .resetn (resetn),
    .en     (push),
    .ptr    (wr_ptr)
  );

  shift8_wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk    (clk),
    .resetn (resetn),
    .en     (pop),
    .ptr    (rd_ptr)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) count_q <= '0;
    else         count_q <= count_d;
  end

  // Storage contents are don't-care after reset; emptiness masks them.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef SHIFT8_FIFO_DROPCNT_EN
  logic [7:0] drop_cnt_q;
  logic [7:0] drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) drop_cnt_q <= '0;
    else         drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
  assign overflow = (drop_cnt_q != 8'h00);
`else
  logic overflow_q;
  logic overflow_d;

  always_comb begin
    overflow_d = overflow_q | drop;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) overflow_q <= 1'b0;
    else         overflow_q <= overflow_d;
  end

  assign overflow = overflow_q;
`endif

  assign count         = count_q;
  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign bus.out_data  = empty ? '0 : mem_q[rd_ptr];

endmodule

`default_nettype wire

// File: tb/tb_shift8_byte_fifo.sv
// ============================================================================
// Module   : tb_shift8_byte_fifo
// Brief    : Directed plus random checks of shift8_byte_fifo against a
//            queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift8_byte_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk;
  logic             resetn;
  logic [CNT_W-1:0] count;
  logic             overflow;
`ifdef SHIFT8_FIFO_DROPCNT_EN
  logic [7:0]       drop_cnt;
`endif

  shift8_byte_fifo_if #(.WIDTH(WIDTH)) bus ();

  shift8_byte_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .bus      (bus),
    .count    (count),
`ifdef SHIFT8_FIFO_DROPCNT_EN
    .drop_cnt (drop_cnt),
`endif
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model
  logic [7:0] mq[$];
  bit         m_ovf;
  int         m_drops;

  int n_checks;
  int n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".count"},     32'(count),         32'(mq.size()));
    check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(mq.size() != 0));
    check({tag, ".in_ready"},  32'(bus.in_ready),  32'(mq.size() != DEPTH));
    check({tag, ".out_data"},  32'(bus.out_data),  (mq.size() != 0) ? 32'(mq[0]) : 32'h0);
    check({tag, ".overflow"},  32'(overflow),      32'(m_ovf));
`ifdef SHIFT8_FIFO_DROPCNT_EN
    check({tag, ".drop_cnt"},  32'(drop_cnt),      32'(m_drops));
`endif
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf   = 1'b0;
    m_drops = 0;
  endtask

  // One clock with the currently driven inputs, then model update and check.
  task automatic step(input string tag);
    bit       full, pop, push, drop;
    bit [7:0] din;
    full = (mq.size() == DEPTH);
    pop  = (mq.size() != 0) && bus.out_ready;
    push = bus.in_valid && !full;
    drop = bus.in_valid && full;
    din  = bus.in_data;
    @(posedge clk);
    #1;
    if (pop)  void'(mq.pop_front());
    if (push) mq.push_back(din);
    if (drop) begin
      m_ovf = 1'b1;
      if (m_drops < 255) m_drops++;
    end
    check_state(tag);
  endtask

  task automatic drive(input bit v, input logic [7:0] d, input bit r);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
  endtask

  task automatic async_reset(input string tag);
    #2;
    resetn = 1'b0;
    model_reset();
    #1;
    check_state(tag);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  logic [7:0] seen;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    model_reset();
    resetn = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_state("reset");
    @(negedge clk);
    resetn = 1'b1;

    // Reset mid-run after three pushes
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'h30 + 8'(i), 1'b0);
      step("pre_rst");
    end
    drive(1'b0, 8'h00, 1'b0);
    async_reset("mid_rst");
    check("mid_rst.count0", 32'(count), 32'd0);

    // Fill and drain
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'hA1 + 8'(i), 1'b0);
      step("fill");
    end
    check("fill.count4", 32'(count), 32'd4);
    check("fill.in_ready0", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      seen = bus.out_data;
      check("drain.order", 32'(seen), 32'hA1 + 32'(i));
      drive(1'b0, 8'h00, 1'b1);
      step("drain");
    end
    check("drain.empty", 32'(bus.out_valid), 32'd0);

    // Drop while full even with a same-cycle pop
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'hB1 + 8'(i), 1'b0);
      step("refill");
    end
    drive(1'b1, 8'hFF, 1'b1);
    step("drop");
    check("drop.count3", 32'(count), 32'd3);
    check("drop.overflow", 32'(overflow), 32'd1);
    for (int i = 0; i < 3; i++) begin
      check("drop.no_ff", 32'(bus.out_data == 8'hFF), 32'd0);
      drive(1'b0, 8'h00, 1'b1);
      step("drop_drain");
    end

    // Steady stream across the pointer wrap
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 8'(i), 1'b1);
      step("stream");
      check("stream.count1", 32'(count), 32'd1);
      check("stream.lag", 32'(bus.out_data), 32'(i));
    end
    drive(1'b0, 8'h00, 1'b1);
    step("stream_end");

    // Empty with simultaneous push and ready
    drive(1'b1, 8'h5A, 1'b1);
    step("empty_sim");
    check("empty_sim.data", 32'(bus.out_data), 32'h5A);
    check("empty_sim.count", 32'(count), 32'd1);

`ifdef SHIFT8_FIFO_DROPCNT_EN
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'hC0 + 8'(i), 1'b0);
      step("sat_fill");
    end
    for (int i = 0; i < 260; i++) begin
      drive(1'b1, 8'hEE, 1'b0);
      step("sat");
    end
    check("sat.drop_cnt", 32'(drop_cnt), 32'd255);
    check("sat.overflow", 32'(overflow), 32'd1);
`endif

    // Randomized traffic, with one asynchronous reset in the middle
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 1)));
      step("rand");
      if (i == 200) begin
        drive(1'b0, 8'h00, 1'b0);
        async_reset("rand_rst");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
